// File: rtl/colour_arbiter.sv
`timescale 1ns/1ps
// -----------------------------------------------------------------------------
// colour_arbiter
//
// Shares one registered RGB colour converter between two requesters, A and B.
// Grants are round-robin. Each transaction takes these steps:
//   1. Pulse the converter enable for exactly one cycle.
//   2. Wait out the converter latency.
//   3. Capture the converter output into rgb_out.
//   4. Pulse done_a or done_b for one cycle.
// This block is the only driver of the converter's colour and enable inputs.
//
// Parameters
//   CONV_LATENCY  cycles from the converter enable edge to valid conv_rgb
//                 (legal range 1..15)
//
// Ports
//   clk          system clock, rising edge
//   rst          synchronous active-high reset
//   req_a        requester A request, held high until done_a
//   colour_a     requester A 3-bit colour code, sampled in the grant cycle
//   req_b        requester B request
//   colour_b     requester B 3-bit colour code
//   done_a       one-cycle pulse, rgb_out holds A's result
//   done_b       one-cycle pulse, rgb_out holds B's result
//   rgb_out      registered result of the last completed conversion
//   busy         high whenever the sequencer is not idle
//   conv_colour  converter colour input
//   conv_enable  converter enable input
//   conv_rgb     converter rgb output
// -----------------------------------------------------------------------------
module colour_arbiter #(
  parameter int CONV_LATENCY = 1
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        req_a,
  input  logic [2:0]  colour_a,
  input  logic        req_b,
  input  logic [2:0]  colour_b,
  output logic        done_a,
  output logic        done_b,
  output logic [23:0] rgb_out,
  output logic        busy,
  output logic [2:0]  conv_colour,
  output logic        conv_enable,
  input  logic [23:0] conv_rgb
);

  localparam int                CNT_W    = 4;
  localparam logic [CNT_W-1:0]  LAT_LOAD = CNT_W'(CONV_LATENCY);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ISSUE = 2'd1,
    WAIT  = 2'd2,
    DONE  = 2'd3
  } state_t;

  // Round-robin choice. prio_b set means B wins a tie.
  function automatic logic pick_b(input logic ra, input logic rb, input logic prio_b);
    return rb && (!ra || prio_b);
  endfunction

  state_t             state_q, state_d;
  logic               grant_b_q, grant_b_d;   // 0: A owns the transaction, 1: B
  logic               prio_b_q, prio_b_d;     // 0: A wins the next tie
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic [2:0]         conv_colour_q, conv_colour_d;
  logic               conv_enable_q, conv_enable_d;
  logic [23:0]        rgb_out_q, rgb_out_d;
  logic               busy_q, busy_d;
  logic               done_a_q, done_a_d;
  logic               done_b_q, done_b_d;

  // Next-state and datapath decisions
  always_comb begin
    state_d       = state_q;
    grant_b_d     = grant_b_q;
    prio_b_d      = prio_b_q;
    cnt_d         = cnt_q;
    conv_colour_d = conv_colour_q;
    rgb_out_d     = rgb_out_q;

    case (state_q)
      IDLE: begin
        if (req_a || req_b) begin
          grant_b_d     = pick_b(req_a, req_b, prio_b_q);
          conv_colour_d = grant_b_d ? colour_b : colour_a;
          state_d       = ISSUE;
        end
      end
      ISSUE: begin
        cnt_d   = LAT_LOAD;
        state_d = WAIT;
      end
      WAIT: begin
        cnt_d = cnt_q - 4'd1;
        // "<= 1" rather than "== 1" so a corrupted zero count cannot wrap
        // and stall the sequencer for 15 extra cycles.
        if (cnt_q <= 4'd1) begin
          cnt_d     = '0;
          rgb_out_d = conv_rgb;
          state_d   = DONE;
        end
      end
      DONE: begin
        prio_b_d = !grant_b_q;
        state_d  = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase

    // Outputs are registered off the next state, so they line up with the
    // state they describe instead of lagging it by a cycle.
    busy_d        = (state_d != IDLE);
    conv_enable_d = (state_d == ISSUE);
    done_a_d      = (state_d == DONE) && !grant_b_d;
    done_b_d      = (state_d == DONE) &&  grant_b_d;
  end

  // State register
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q       <= IDLE;
      grant_b_q     <= 1'b0;
      prio_b_q      <= 1'b0;
      cnt_q         <= '0;
      conv_colour_q <= 3'b000;
      conv_enable_q <= 1'b0;
      rgb_out_q     <= 24'h000000;
      busy_q        <= 1'b0;
      done_a_q      <= 1'b0;
      done_b_q      <= 1'b0;
    end else begin
      state_q       <= state_d;
      grant_b_q     <= grant_b_d;
      prio_b_q      <= prio_b_d;
      cnt_q         <= cnt_d;
      conv_colour_q <= conv_colour_d;
      conv_enable_q <= conv_enable_d;
      rgb_out_q     <= rgb_out_d;
      busy_q        <= busy_d;
      done_a_q      <= done_a_d;
      done_b_q      <= done_b_d;
    end
  end

  assign done_a      = done_a_q;
  assign done_b      = done_b_q;
  assign rgb_out     = rgb_out_q;
  assign busy        = busy_q;
  assign conv_colour = conv_colour_q;
  assign conv_enable = conv_enable_q;

endmodule

// File: tb/tb_colour_arbiter.sv
`timescale 1ns/1ps
module tb_colour_arbiter;

  logic        clk = 1'b0;
  logic        rst;
  logic        req_a, req_b;
  logic [2:0]  colour_a, colour_b;
  logic        done_a, done_b, busy, conv_enable;
  logic [23:0] rgb_out;
  logic [2:0]  conv_colour;
  logic [23:0] conv_rgb = 24'h0;

  // Second instance with a 3-cycle converter
  logic        req_a3, req_b3;
  logic [2:0]  colour_a3, colour_b3;
  logic        done_a3, done_b3, busy3, conv_enable3;
  logic [23:0] rgb_out3;
  logic [2:0]  conv_colour3;
  logic [23:0] conv_rgb3;
  logic [23:0] s0 = 24'h0, s1 = 24'h0, s2 = 24'h0;

  int nvec  = 0;
  int nfail = 0;

  always #5 clk = ~clk;

  function automatic logic [23:0] cmap(input logic [2:0] c);
    return {{8{c[2]}}, {8{c[1]}}, {8{c[0]}}};
  endfunction

  always_ff @(posedge clk) if (conv_enable) conv_rgb <= cmap(conv_colour);

  always_ff @(posedge clk) begin
    if (conv_enable3) s0 <= cmap(conv_colour3);
    s1 <= s0;
    s2 <= s1;
  end
  assign conv_rgb3 = s2;

  colour_arbiter #(.CONV_LATENCY(1)) dut (
    .clk(clk), .rst(rst),
    .req_a(req_a), .colour_a(colour_a), .req_b(req_b), .colour_b(colour_b),
    .done_a(done_a), .done_b(done_b), .rgb_out(rgb_out), .busy(busy),
    .conv_colour(conv_colour), .conv_enable(conv_enable), .conv_rgb(conv_rgb)
  );

  colour_arbiter #(.CONV_LATENCY(3)) dut3 (
    .clk(clk), .rst(rst),
    .req_a(req_a3), .colour_a(colour_a3), .req_b(req_b3), .colour_b(colour_b3),
    .done_a(done_a3), .done_b(done_b3), .rgb_out(rgb_out3), .busy(busy3),
    .conv_colour(conv_colour3), .conv_enable(conv_enable3), .conv_rgb(conv_rgb3)
  );

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    nvec++;
    if (act !== exp) begin
      nfail++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  // Inputs applied before an edge; expected outputs are those seen just after it.
  typedef struct packed {
    logic        rst;
    logic        ra;
    logic [2:0]  ca;
    logic        rb;
    logic [2:0]  cb;
    logic        da;
    logic        db;
    logic        bsy;
    logic        en;
    logic [2:0]  col;
    logic [23:0] rgb;
  } vec_t;

  vec_t vt [15];

  initial begin
    int ndone, last, nen;
    logic found;

    //          rst  ra   ca     rb   cb      da   db   bsy  en   col     rgb
    vt[0]  = '{1'b1,1'b0,3'b000,1'b0,3'b000, 1'b0,1'b0,1'b0,1'b0,3'b000,24'h000000};
    vt[1]  = '{1'b1,1'b0,3'b000,1'b0,3'b000, 1'b0,1'b0,1'b0,1'b0,3'b000,24'h000000};
    vt[2]  = '{1'b0,1'b0,3'b000,1'b1,3'b111, 1'b0,1'b0,1'b1,1'b1,3'b111,24'h000000};
    vt[3]  = '{1'b0,1'b0,3'b000,1'b1,3'b111, 1'b0,1'b0,1'b1,1'b0,3'b111,24'h000000};
    vt[4]  = '{1'b0,1'b0,3'b000,1'b1,3'b111, 1'b0,1'b1,1'b1,1'b0,3'b111,24'hFFFFFF};
    vt[5]  = '{1'b0,1'b0,3'b000,1'b0,3'b000, 1'b0,1'b0,1'b0,1'b0,3'b111,24'hFFFFFF};
    vt[6]  = '{1'b0,1'b1,3'b100,1'b0,3'b000, 1'b0,1'b0,1'b1,1'b1,3'b100,24'hFFFFFF};
    vt[7]  = '{1'b0,1'b1,3'b100,1'b0,3'b000, 1'b0,1'b0,1'b1,1'b0,3'b100,24'hFFFFFF};
    vt[8]  = '{1'b0,1'b1,3'b100,1'b0,3'b000, 1'b1,1'b0,1'b1,1'b0,3'b100,24'hFF0000};
    vt[9]  = '{1'b0,1'b0,3'b100,1'b0,3'b000, 1'b0,1'b0,1'b0,1'b0,3'b100,24'hFF0000};
    vt[10] = '{1'b0,1'b0,3'b000,1'b0,3'b000, 1'b0,1'b0,1'b0,1'b0,3'b100,24'hFF0000};
    vt[11] = '{1'b0,1'b1,3'b011,1'b0,3'b000, 1'b0,1'b0,1'b1,1'b1,3'b011,24'hFF0000};
    vt[12] = '{1'b0,1'b1,3'b000,1'b0,3'b000, 1'b0,1'b0,1'b1,1'b0,3'b011,24'hFF0000};
    vt[13] = '{1'b0,1'b0,3'b000,1'b0,3'b000, 1'b1,1'b0,1'b1,1'b0,3'b011,24'h00FFFF};
    vt[14] = '{1'b0,1'b0,3'b000,1'b0,3'b000, 1'b0,1'b0,1'b0,1'b0,3'b011,24'h00FFFF};

    rst = 1'b1;
    req_a = 1'b0; req_b = 1'b0; colour_a = 3'b000; colour_b = 3'b000;
    req_a3 = 1'b0; req_b3 = 1'b0; colour_a3 = 3'b000; colour_b3 = 3'b000;

    for (int i = 0; i < 15; i++) begin
      rst = vt[i].rst; req_a = vt[i].ra; colour_a = vt[i].ca;
      req_b = vt[i].rb; colour_b = vt[i].cb;
      @(posedge clk); #1;
      check($sformatf("v%0d done_a", i),      done_a,      vt[i].da);
      check($sformatf("v%0d done_b", i),      done_b,      vt[i].db);
      check($sformatf("v%0d busy", i),        busy,        vt[i].bsy);
      check($sformatf("v%0d conv_enable", i), conv_enable, vt[i].en);
      check($sformatf("v%0d conv_colour", i), conv_colour, vt[i].col);
      check($sformatf("v%0d rgb_out", i),     rgb_out,     vt[i].rgb);
    end

    // Tie and fairness: both held continuously after a reset.
    rst = 1'b1; req_a = 1'b0; req_b = 1'b0;
    @(posedge clk); #1;
    rst = 1'b0; req_a = 1'b1; colour_a = 3'b010; req_b = 1'b1; colour_b = 3'b001;
    ndone = 0; last = 0;
    for (int c = 0; c < 30 && ndone < 4; c++) begin
      @(posedge clk); #1;
      check("tie exclusive done", {31'b0, done_a & done_b}, 32'd0);
      if (done_a || done_b) begin
        check($sformatf("tie%0d done_a", ndone), done_a, (ndone % 2 == 0));
        check($sformatf("tie%0d rgb_out", ndone), rgb_out,
              (ndone % 2 == 0) ? 24'h00FF00 : 24'h0000FF);
        if (ndone == 0) check("tie first latency", c, 2);
        else            check($sformatf("tie%0d gap", ndone), c - last, 4);
        last = c;
        ndone++;
      end
    end
    check("tie done count", ndone, 4);

    // Reset during WAIT aborts the transaction without a done pulse.
    req_a = 1'b0; req_b = 1'b0;
    @(posedge clk); #1;
    check("pre-reset rgb_out", rgb_out, 24'h0000FF);
    req_a = 1'b1; colour_a = 3'b110;
    @(posedge clk); #1;
    @(posedge clk); #1;
    check("mid busy in wait", busy, 1);
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    check("mid done_a", done_a, 0);
    check("mid busy", busy, 0);
    check("mid rgb_out", rgb_out, 24'h000000);
    check("mid conv_enable", conv_enable, 0);
    check("mid conv_colour", conv_colour, 3'b000);
    found = 1'b0;
    for (int k = 1; k <= 10 && !found; k++) begin
      @(posedge clk); #1;
      check("mid done_b", done_b, 0);
      if (done_a) begin
        found = 1'b1;
        check("mid fresh latency", k, 3);
        check("mid fresh rgb_out", rgb_out, 24'hFFFF00);
      end
    end
    check("mid fresh done seen", found, 1);
    req_a = 1'b0;
    @(posedge clk); #1;

    // Latency 3 on the second instance.
    req_b3 = 1'b1; colour_b3 = 3'b101;
    nen = 0; found = 1'b0;
    for (int k = 1; k <= 12 && !found; k++) begin
      @(posedge clk); #1;
      if (conv_enable3) nen++;
      check("lat3 done_a", done_a3, 0);
      if (done_b3) begin
        found = 1'b1;
        check("lat3 latency", k, 5);
        check("lat3 rgb_out", rgb_out3, 24'hFF00FF);
      end
    end
    check("lat3 done seen", found, 1);
    check("lat3 enable cycles", nen, 1);
    req_b3 = 1'b0;
    @(posedge clk); #1;
    check("lat3 idle busy", busy3, 0);

    $display("== %0d vectors applied, %0d miscompares ==", nvec, nfail);
    $finish;
  end

endmodule

// File: doc/colour_arbiter.md
# colour_arbiter

Shares a single RGB colour converter (3-bit colour code in, 24-bit RGB out, one registered stage gated by `enable`) between two independent requesters, A and B. Grants are round-robin. The block sequences each conversion: it drives the converter for exactly one cycle, waits out the converter latency, captures the result, and returns it to the granted requester with a one-cycle done pulse. It sits between the two clients and the converter instance, and is the only driver of the converter's `colour` and `enable` inputs.

## Interface

- `CONV_LATENCY`, default 1: clock cycles from the converter `enable` edge to valid `rgb`; legal range 1–15.

- Clocking: one clock; reset is synchronous and active-high.
- `clk`  in  1  system clock; all state changes on the rising edge.
- `rst`  in  1  synchronous, active-high reset.
- `req_a`  in  1  requester A wants a conversion; held high until `done_a`.
- `colour_a`  in  3  requester A colour code; sampled only in the cycle A is granted.
- `req_b`  in  1  requester B request; same rules as A.
- `colour_b`  in  3  requester B colour code.
- `done_a`  out  1  one-cycle pulse: `rgb_out` holds A's result.
- `done_b`  out  1  one-cycle pulse: `rgb_out` holds B's result.
- `rgb_out`  out  24  registered result of the last completed conversion.
- `busy`  out  1  high whenever the FSM is not in IDLE.
- `conv_colour`  out  3  drives converter `colour`.
- `conv_enable`  out  1  drives converter `enable`.
- `conv_rgb`  in  24  converter `rgb` output.

## Operation

- FSM states: IDLE, ISSUE, WAIT, DONE.
- **IDLE**
  - If no request is pending, stay in IDLE.
  - If exactly one request is pending, grant it.
  - If both `req_a` and `req_b` are high, grant the requester that was not served last. The priority pointer resets to A, so A wins the first tie after reset.
  - On grant: latch the requester's colour into `conv_colour`, record the grant ID, go to ISSUE.
- **ISSUE** (one cycle)
  - `conv_enable` = 1; `conv_colour` = latched code.
  - Load the wait counter with `CONV_LATENCY`.
  - Go to WAIT.
- **WAIT**
  - `conv_enable` = 0, so the converter holds its value.
  - Decrement the counter each cycle.
  - In the cycle the counter equals 1, capture `conv_rgb` into `rgb_out` and go to DONE.
- **DONE** (one cycle)
  - Assert `done_a` or `done_b` according to the grant ID.
  - Flip the priority pointer to the other requester.
  - Go to IDLE.
- `conv_enable` is high only in ISSUE: exactly one cycle per transaction.
- `conv_colour` holds its value outside ISSUE.
- `rgb_out` changes only on capture. It holds the previous result otherwise, including across later grants.
- Handshake rules:
  - The client must hold `req` high until it sees `done`, then drop it by the next edge.
  - A `req` that falls mid-transaction is ignored. The transaction completes and `done` still pulses.
  - A `req` still high in the IDLE cycle after DONE counts as a new request.
- A colour code that changes after grant has no effect on the transaction in flight.
- `done_a` and `done_b` are never high together.
- Colour mapping (owned by the converter, listed for checking): bit2 → R = FF, bit1 → G = FF, bit0 → B = FF. Examples: 3'b001 → 0000FF, 3'b110 → FFFF00.

## Timing

- Reset (`rst` high at a rising edge), regardless of current state:
  - State → IDLE; transaction aborted; no `done` pulse is issued for it.
  - `done_a`, `done_b`, `busy`, `conv_enable` → 0.
  - `conv_colour` → 3'b000; `rgb_out` → 24'h000000; priority pointer → A; wait counter → 0.
- Request sampled in IDLE cycle N:
  - ISSUE in N+1.
  - WAIT in N+2 … N+1+`CONV_LATENCY`.
  - DONE in N+2+`CONV_LATENCY`.
  - With default latency: `done` at N+3, and `rgb_out` is valid in that same cycle.
- Throughput: one transaction per 3+`CONV_LATENCY` cycles (IDLE included). With both requesters saturating, grants strictly alternate A, B, A, …
- `busy` is registered. It is high from ISSUE through DONE inclusive.

## Test plan

- **Reset values:** hold `rst` high for 2 cycles → every output 0, `rgb_out` = 000000; then raise `req_b` with `colour_b` = 3'b111 → first grant to B.
- **Single request, default latency:** `req_a` high with `colour_a` = 3'b100 in cycle N → `conv_enable` high only in N+1; `done_a` pulses in N+3 with `rgb_out` = FF0000; `done_b` stays 0.
- **Tie and fairness:** `req_a` and `req_b` held continuously, `colour_a` = 3'b010, `colour_b` = 3'b001 → results alternate 00FF00 (A) then 0000FF (B); A is first after reset; exactly 4 cycles between `done` pulses.
- **Early drop and late colour change:** A granted with 3'b011, then `req_a` drops and `colour_a` changes to 3'b000 during WAIT → `done_a` still pulses with `rgb_out` = 00FFFF.
- **Reset mid-transaction:** `rst` asserted during WAIT → no `done` pulse; `busy` = 0 and `rgb_out` = 000000 next cycle; a fresh request then completes normally.
- **Latency parameter:** `CONV_LATENCY` = 3 with a delayed converter model, `colour_b` = 3'b101 → `done_b` exactly 5 cycles after the request cycle, with `rgb_out` = FF00FF.
